// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store. One transaction is in flight at a time, and every output is registered.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clk_en,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_done,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_done,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

   logic [1:0] state;
   logic [3:0] cnt;
   logic       owner;
   logic       last_owner;
   logic       grant_dm;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant_dm = dm_req && (!if_req || (last_owner == OWN_IF));
   end

   // mem_addr/mem_we/mem_wdata double as the transaction latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         owner      <= OWN_IF;
         last_owner <= OWN_DM;
         if_done    <= 1'b0;
         if_rdata   <= '0;
         dm_done    <= 1'b0;
         dm_rdata   <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
      end else if (clk_en) begin
         case (state)
            IDLE: begin
               if (if_req || dm_req) begin
                  owner    <= grant_dm;
                  mem_en   <= 1'b1;
                  mem_we   <= grant_dm ? dm_we : 1'b0;
                  mem_addr <= grant_dm ? dm_addr : if_addr;
                  if (grant_dm) begin
                     mem_wdata <= dm_wdata;
                  end
                  busy  <= 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               if (mem_we) begin
                  dm_done <= 1'b1;
                  state   <= RESP;
               end else begin
                  cnt   <= CNT_INIT;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  if (owner == OWN_DM) begin
                     dm_rdata <= mem_rdata;
                     dm_done  <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_done  <= 1'b1;
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if_done    <= 1'b0;
               dm_done    <= 1'b0;
               last_owner <= owner;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drivers push expected memory issues and
// done responses into queues, and a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

   localparam int   LAT  = 3;
   localparam logic P_IF = 1'b0;
   localparam logic P_DM = 1'b1;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_done;
   logic [31:0] dm_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_done(dm_done), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // memory model: read data is addr ^ 0x2002_0045, LAT enabled cycles after mem_en
   logic [31:0] rd_pipe [0:LAT-1];
   always @(posedge clk) begin
      if (clk_en) begin
         rd_pipe[0] <= (mem_en && !mem_we) ? (mem_addr ^ 32'h2002_0045) : 32'h0;
         for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end
   assign mem_rdata = rd_pipe[LAT-1];

   // scoreboard
   logic [96:0] mem_q[$];   // {we, addr, wdata, cycle}
   logic [64:0] done_q[$];  // {port, rdata, cycle}
   int n_cmp = 0;
   int n_err = 0;

   always @(negedge clk) begin : monitor
      logic [96:0] me;
      logic [64:0] de;
      logic        got_port;
      logic [31:0] got_rd;
      if (clk_en === 1'b1 && mem_en === 1'b1) begin
         n_cmp++;
         if (mem_q.size() == 0) begin
            n_err++;
            $display("FAIL mem_issue: unexpected mem_en at cycle %0d addr=%h, required none", cyc, mem_addr);
         end else begin
            me = mem_q.pop_front();
            if (mem_we !== me[96] || mem_addr !== me[95:64] ||
                (me[96] && mem_wdata !== me[63:32]) || cyc != int'(me[31:0])) begin
               n_err++;
               $display("FAIL mem_issue: got we=%b addr=%h wdata=%h cycle=%0d, required we=%b addr=%h wdata=%h cycle=%0d",
                        mem_we, mem_addr, mem_wdata, cyc, me[96], me[95:64], me[63:32], int'(me[31:0]));
            end
         end
      end
      if (clk_en === 1'b1 && (if_done === 1'b1 || dm_done === 1'b1)) begin
         n_cmp++;
         if (if_done === 1'b1 && dm_done === 1'b1) begin
            n_err++;
            $display("FAIL done_excl: if_done=1 dm_done=1 at cycle %0d, required at most one", cyc);
         end else if (done_q.size() == 0) begin
            n_err++;
            $display("FAIL done_pulse: unexpected if_done=%b dm_done=%b at cycle %0d, required none", if_done, dm_done, cyc);
         end else begin
            de       = done_q.pop_front();
            got_port = (dm_done === 1'b1);
            got_rd   = got_port ? dm_rdata : if_rdata;
            if (got_port !== de[64] || got_rd !== de[63:32] || cyc != int'(de[31:0])) begin
               n_err++;
               $display("FAIL done_pulse: got port=%b rdata=%h cycle=%0d, required port=%b rdata=%h cycle=%0d",
                        got_port, got_rd, cyc, de[64], de[63:32], int'(de[31:0]));
            end
         end
      end
   end

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int c);
      mem_q.push_back({we, addr, wdata, 32'(c)});
   endtask

   task automatic push_done(input logic port, input logic [31:0] rd, input int c);
      done_q.push_back({port, rd, 32'(c)});
   endtask

   task automatic check_reset(input string name);
      n_cmp++;
      if ({if_done, dm_done, mem_en, mem_we, busy} !== 5'b0 || if_rdata !== 32'h0 ||
          dm_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         n_err++;
         $display("FAIL %s: got if_done=%b dm_done=%b mem_en=%b mem_we=%b busy=%b if_rdata=%h dm_rdata=%h mem_addr=%h mem_wdata=%h, required all 0",
                  name, if_done, dm_done, mem_en, mem_we, busy, if_rdata, dm_rdata, mem_addr, mem_wdata);
      end
   endtask

   // single transaction from an idle arbiter; req dropped the cycle after done
   task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd);
      int c0;
      int lat;
      c0  = cyc;
      lat = we ? 2 : 2 + LAT;
      if (port == P_DM) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      push_mem(we, addr, wdata, c0 + 1);
      push_done(port, exp_rd, c0 + lat);
      tick(lat + 1);
      if_req = 1'b0;
      dm_req = 1'b0;
      tick(1);
   endtask

   initial begin : stimulus
      int c0;
      rst = 1'b1; clk_en = 1'b1;
      if_req = 1'b1; if_addr = 32'h0000_0040;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;

      // reset held with if_req high, then first fetch
      tick(1); check_reset("reset_hold_1");
      tick(1); check_reset("reset_hold_2");
      tick(1);
      rst = 1'b0;
      c0  = cyc;
      push_mem(1'b0, 32'h0000_0040, 32'h0, c0 + 1);
      push_done(P_IF, 32'h2002_0005, c0 + 2 + LAT);
      tick(3 + LAT);
      if_req = 1'b0;
      tick(1);

      // load then store on the data port; the store leaves dm_rdata alone
      run_txn(P_DM, 1'b0, 32'h0000_0104, 32'h0, 32'h2002_0141);
      run_txn(P_DM, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h2002_0141);

      // both requesting continuously: IF, DM, IF, DM
      c0 = cyc;
      if_req = 1'b1; if_addr = 32'h0000_0080;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200; dm_wdata = 32'h0;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) begin
            push_mem(1'b0, 32'h0000_0080, 32'h0, c0 + k*(3+LAT) + 1);
            push_done(P_IF, 32'h2002_00C5, c0 + k*(3+LAT) + 2 + LAT);
         end else begin
            push_mem(1'b0, 32'h0000_0200, 32'h0, c0 + k*(3+LAT) + 1);
            push_done(P_DM, 32'h2002_0245, c0 + k*(3+LAT) + 2 + LAT);
         end
      end
      tick(4*(3+LAT));
      if_req = 1'b0; dm_req = 1'b0;
      tick(1);

      // clk_en low for two cycles inside WAIT: done two cycles later
      c0 = cyc;
      if_req = 1'b1; if_addr = 32'h0000_0104;
      push_mem(1'b0, 32'h0000_0104, 32'h0, c0 + 1);
      push_done(P_IF, 32'h2002_0141, c0 + 2 + LAT + 2);
      tick(3); clk_en = 1'b0;
      tick(2); clk_en = 1'b1;
      tick(3);
      if_req = 1'b0;
      tick(1);

      // clk_en low during ISSUE and during RESP: each strobe spans one enabled cycle
      c0 = cyc;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0040;
      push_mem(1'b0, 32'h0000_0040, 32'h0, c0 + 2);
      push_done(P_DM, 32'h2002_0005, c0 + 7);
      tick(1); clk_en = 1'b0;
      tick(1); clk_en = 1'b1;
      tick(4); clk_en = 1'b0;
      tick(1); clk_en = 1'b1;
      tick(1);
      dm_req = 1'b0;
      tick(1);

      // reset during WAIT aborts with no done; a fresh request then completes normally
      c0 = cyc;
      if_req = 1'b1; if_addr = 32'h0000_0040;
      push_mem(1'b0, 32'h0000_0040, 32'h0, c0 + 1);
      tick(2); rst = 1'b1;
      tick(1); rst = 1'b0; if_req = 1'b0;
      check_reset("abort_reset");
      tick(1);
      run_txn(P_DM, 1'b0, 32'h0000_0200, 32'h0, 32'h2002_0245);

      tick(2 * (3 + LAT));
      n_cmp++;
      if (mem_q.size() != 0 || done_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d mem issues and %0d dones still expected, required 0 and 0",
                  mem_q.size(), done_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
